// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one single-port data RAM between an instruction-refill master (M0,
// read bursts) and a load/store master (M1, single-beat reads or writes).
// Round-robin arbitration in IDLE. The winner keeps the RAM until its
// transaction has fully completed, including every outstanding read return.
// Burst beats step by DW/8 bytes and wrap modulo 2^AW.

module ram_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int LW = 2
) (
  input  logic            clk,
  input  logic            rst,

  // M0: instruction-cache line refill (read bursts only)
  input  logic            m0_req,
  input  logic [AW-1:0]   m0_addr,
  input  logic [LW-1:0]   m0_len,
  output logic            m0_done,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,

  // M1: load/store unit (single-beat read or write)
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_wstrb,
  output logic            m1_done,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,

  // Single-port RAM
  output logic            ram_req,
  output logic            ram_we,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_wdata,
  output logic [DW/8-1:0] ram_wstrb,
  input  logic            ram_rvalid,
  input  logic [DW-1:0]   ram_rdata
);

  // Byte stride between consecutive beats, expressed as a shift.
  localparam int BEAT_SHIFT = $clog2(DW / 8);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;

  // Transaction context latched at grant time
  logic            owner;       // 0 = M0, 1 = M1
  logic            last_owner;  // owner of the most recently completed transaction
  logic [AW-1:0]   base;
  logic [LW-1:0]   len;         // beats minus 1
  logic            cur_we;

  // Issue and response progress within the current transaction
  logic [LW-1:0]   beat;
  logic [LW-1:0]   resp;

  // Decoded events
  logic            any_req;
  logic            grant;       // which master wins in IDLE
  logic            rsp_hit;     // a read return belonging to the current owner
  logic            last_issue;  // final beat of the burst is on the bus
  logic            rd_last;     // final read return of the burst
  logic            wr_done;     // the single write beat is on the bus
  logic [AW-1:0]   issue_addr;

  // Round-robin choice: a lone requester wins; on a tie the master that did
  // not own the previous transaction wins.
  always_comb begin
    grant = 1'b0;
    if (m0_req && m1_req) begin
      grant = ~last_owner;
    end else if (m1_req) begin
      grant = 1'b1;
    end
  end

  assign any_req    = m0_req | m1_req;

  // Returns are only meaningful while a read transaction owns the RAM; any
  // return seen in IDLE (for example a leftover from an aborted burst) is dropped.
  assign rsp_hit    = ram_rvalid && (state != IDLE) && !cur_we;
  assign last_issue = (state == ISSUE) && (beat == len);
  assign rd_last    = rsp_hit && (resp == len);
  assign wr_done    = (state == ISSUE) && cur_we;
  assign issue_addr = base + (AW'(beat) << BEAT_SHIFT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every clocked assignment is non-blocking so all flops sample the
    // pre-edge values of each other, independent of process ordering.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // state_next unassigned, which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (wr_done) begin
          state_next = IDLE;
        end else if (last_issue) begin
          // A return that finishes the burst in the same cycle as the final
          // issue skips WAIT entirely.
          state_next = rd_last ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (rd_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Transaction context and beat/response counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= 1'b0;
      last_owner <= 1'b1;
      base       <= '0;
      len        <= '0;
      cur_we     <= 1'b0;
      beat       <= '0;
      resp       <= '0;
    end else if (state == IDLE) begin
      if (any_req) begin
        owner  <= grant;
        base   <= grant ? m1_addr : m0_addr;
        // M1 is always a single beat, whether it reads or writes.
        len    <= grant ? '0 : m0_len;
        cur_we <= grant & m1_we;
        beat   <= '0;
        resp   <= '0;
      end
    end else begin
      if (state == ISSUE) begin
        beat <= beat + 1'b1;
      end
      // Returns can overlap the issue phase, so count them in either state.
      if (rsp_hit) begin
        resp <= resp + 1'b1;
      end
      if (wr_done || rd_last) begin
        last_owner <= owner;
      end
    end
  end

  // Output decode: RAM command, read-return routing, completion pulses
  always_comb begin
    ram_req   = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wstrb = '0;
    m0_rvalid = 1'b0;
    m0_rdata  = '0;
    m1_rvalid = 1'b0;
    m1_rdata  = '0;
    m0_done   = 1'b0;
    m1_done   = 1'b0;

    if (state == ISSUE) begin
      ram_req  = 1'b1;
      ram_addr = issue_addr;
      // Only M1 can write; M0 bursts always present a clean read command.
      if (owner && cur_we) begin
        ram_we    = 1'b1;
        ram_wdata = m1_wdata;
        ram_wstrb = m1_wstrb;
      end
    end

    if (rsp_hit) begin
      if (owner) begin
        m1_rvalid = 1'b1;
        m1_rdata  = ram_rdata;
      end else begin
        m0_rvalid = 1'b1;
        m0_rdata  = ram_rdata;
      end
    end

    m0_done = !owner && rd_last;
    m1_done = owner && (rd_last || wr_done);
  end

  // The RAM is only driven while issuing beats.
  a_req_only_in_issue: assert property (
    @(posedge clk) disable iff (rst) ram_req |-> (state == ISSUE)
  );

  // A read return goes to exactly one master.
  a_rvalid_exclusive: assert property (
    @(posedge clk) disable iff (rst) !(m0_rvalid && m1_rvalid)
  );

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter.
// A behavioural RAM with programmable read latency sits on the RAM port.
// Each transaction's expected cycle-by-cycle behaviour is derived from simple
// arithmetic: beats on cycles 1..len+1 after the grant cycle, returns
// 'lat' cycles later, and done on the last return (or on the write beat).
// A reference memory tracks the expected RAM contents.

module tb_ram_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 2;

  logic           clk = 1'b0;
  logic           rst;

  logic           m0_req;
  logic [AW-1:0]  m0_addr;
  logic [LW-1:0]  m0_len;
  logic           m0_done;
  logic           m0_rvalid;
  logic [DW-1:0]  m0_rdata;

  logic           m1_req;
  logic           m1_we;
  logic [AW-1:0]  m1_addr;
  logic [DW-1:0]  m1_wdata;
  logic [3:0]     m1_wstrb;
  logic           m1_done;
  logic           m1_rvalid;
  logic [DW-1:0]  m1_rdata;

  logic           ram_req;
  logic           ram_we;
  logic [AW-1:0]  ram_addr;
  logic [DW-1:0]  ram_wdata;
  logic [3:0]     ram_wstrb;
  logic           ram_rvalid = 1'b0;
  logic [DW-1:0]  ram_rdata  = '0;

  int checks   = 0;
  int failures = 0;
  int txn_id   = 0;
  int lat      = 1;     // RAM read latency in cycles, 1..8
  bit ref_last = 1'b1;  // model of which master completed last

  logic [31:0] ref_mem [256];

  always #5 clk = ~clk;

  ram_port_arbiter #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .m0_req     (m0_req),
    .m0_addr    (m0_addr),
    .m0_len     (m0_len),
    .m0_done    (m0_done),
    .m0_rvalid  (m0_rvalid),
    .m0_rdata   (m0_rdata),
    .m1_req     (m1_req),
    .m1_we      (m1_we),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_wstrb   (m1_wstrb),
    .m1_done    (m1_done),
    .m1_rvalid  (m1_rvalid),
    .m1_rdata   (m1_rdata),
    .ram_req    (ram_req),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_wstrb  (ram_wstrb),
    .ram_rvalid (ram_rvalid),
    .ram_rdata  (ram_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  // Behavioural RAM: 256 words indexed by addr[9:2], fixed read latency,
  // not affected by the arbiter's reset (late returns keep coming).
  logic [31:0] ram_mem [256];
  bit          pv [8];
  logic [31:0] pd [8];
  bit          ram_inited = 1'b0;

  always @(posedge clk) begin
    if (!ram_inited) begin
      for (int i = 0; i < 256; i++) ram_mem[i] = init_word(i);
      for (int i = 0; i < 8; i++) begin
        pv[i] = 1'b0;
        pd[i] = '0;
      end
      ram_inited = 1'b1;
    end
    for (int i = 0; i < 7; i++) begin
      pv[i] = pv[i+1];
      pd[i] = pd[i+1];
    end
    pv[7] = 1'b0;
    pd[7] = '0;
    if (ram_req === 1'b1) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_wstrb[b]) ram_mem[ram_addr[9:2]][8*b +: 8] = ram_wdata[8*b +: 8];
      end else begin
        pv[lat-1] = 1'b1;
        pd[lat-1] = ram_mem[ram_addr[9:2]];
      end
    end
    ram_rvalid <= pv[0];
    ram_rdata  <= pv[0] ? pd[0] : 32'h0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s txn=%0d observed=%0h expected=%0h", tag, txn_id, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at the negedge of the IDLE cycle in which the owner's request is
  // visible. Steps through to the done cycle, checking every output.
  task automatic expect_txn(input bit own, input logic [31:0] base, input int len,
                            input bit we, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input bit drop);
    int          done_k;
    bit          exp_req;
    bit          exp_v;
    logic [31:0] a;
    txn_id++;
    done_k = we ? 1 : 1 + len + lat;
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) ref_mem[base[9:2]][8*b +: 8] = wdata[8*b +: 8];
    end
    check("idle_ram_req", ram_req, 0);
    check("idle_m0_done", m0_done, 0);
    check("idle_m1_done", m1_done, 0);
    check("idle_m0_rvalid", m0_rvalid, 0);
    check("idle_m1_rvalid", m1_rvalid, 0);
    for (int k = 1; k <= done_k; k++) begin
      next_cycle();
      exp_req = (k <= len + 1);
      check("ram_req", ram_req, exp_req);
      if (exp_req) begin
        a = base + 32'(4 * (k - 1));
        check("ram_addr", ram_addr, a);
        check("ram_we", ram_we, we);
        check("ram_wstrb", ram_wstrb, we ? wstrb : 4'h0);
        if (we) check("ram_wdata", ram_wdata, wdata);
      end
      exp_v = !we && (k >= 1 + lat);
      check("owner_rvalid", own ? m1_rvalid : m0_rvalid, exp_v);
      check("other_rvalid", own ? m0_rvalid : m1_rvalid, 0);
      if (exp_v) begin
        a = base + 32'(4 * (k - 1 - lat));
        check("owner_rdata", own ? m1_rdata : m0_rdata, ref_mem[a[9:2]]);
      end
      check("owner_done", own ? m1_done : m0_done, k == done_k);
      check("other_done", own ? m0_done : m1_done, 0);
    end
    if (drop) begin
      if (own) m1_req = 1'b0;
      else     m0_req = 1'b0;
    end
    ref_last = own;
  endtask

  task automatic set_m0(input logic [31:0] addr, input int len);
    m0_addr = addr;
    m0_len  = LW'(len);
    m0_req  = 1'b1;
  endtask

  task automatic set_m1(input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb);
    m1_we    = we;
    m1_addr  = addr;
    m1_wdata = wdata;
    m1_wstrb = wstrb;
    m1_req   = 1'b1;
  endtask

  task automatic apply_reset();
    rst    = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (3) next_cycle();
    check("rst_ram_req", ram_req, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_ram_wstrb", ram_wstrb, 0);
    check("rst_m0_done", m0_done, 0);
    check("rst_m1_done", m1_done, 0);
    check("rst_m0_rvalid", m0_rvalid, 0);
    check("rst_m1_rvalid", m1_rvalid, 0);
    check("rst_m0_rdata", m0_rdata, 0);
    check("rst_m1_rdata", m1_rdata, 0);
    rst      = 1'b0;
    ref_last = 1'b1;
  endtask

  initial begin
    int          kind;
    bit          first;
    bit          w;
    int          l;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] wd;
    logic [3:0]  ws;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    rst      = 1'b1;
    m0_req   = 1'b0;
    m0_addr  = '0;
    m0_len   = '0;
    m1_req   = 1'b0;
    m1_we    = 1'b0;
    m1_addr  = '0;
    m1_wdata = '0;
    m1_wstrb = '0;

    apply_reset();

    // M0 burst of 4 at 0x100, latency 1
    lat = 1;
    set_m0(32'h100, 3);
    expect_txn(1'b0, 32'h100, 3, 1'b0, '0, '0, 1'b1);
    next_cycle();

    // M1 full-word write, then read it back
    set_m1(1'b1, 32'h20, 32'hDEAD_BEEF, 4'hF);
    expect_txn(1'b1, 32'h20, 0, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1);
    next_cycle();
    set_m1(1'b0, 32'h20, '0, '0);
    expect_txn(1'b1, 32'h20, 0, 1'b0, '0, '0, 1'b1);
    next_cycle();

    // Both request right after reset, both held: M0, M1, M0, then M1 alone
    apply_reset();
    set_m0(32'h200, 1);
    set_m1(1'b0, 32'h40, '0, '0);
    expect_txn(1'b0, 32'h200, 1, 1'b0, '0, '0, 1'b0);
    next_cycle();
    expect_txn(1'b1, 32'h40, 0, 1'b0, '0, '0, 1'b0);
    next_cycle();
    expect_txn(1'b0, 32'h200, 1, 1'b0, '0, '0, 1'b1);
    next_cycle();
    expect_txn(1'b1, 32'h40, 0, 1'b0, '0, '0, 1'b1);
    next_cycle();

    // Latency 3: burst finishes in WAIT with no RAM strobes
    lat = 3;
    set_m0(32'h300, 3);
    expect_txn(1'b0, 32'h300, 3, 1'b0, '0, '0, 1'b1);
    next_cycle();

    // Partial-strobe write and readback
    lat = 2;
    set_m1(1'b1, 32'h44, 32'h1122_3344, 4'h5);
    expect_txn(1'b1, 32'h44, 0, 1'b1, 32'h1122_3344, 4'h5, 1'b1);
    next_cycle();
    set_m1(1'b0, 32'h44, '0, '0);
    expect_txn(1'b1, 32'h44, 0, 1'b0, '0, '0, 1'b1);
    next_cycle();

    // Burst crossing the top of the address space wraps to 0
    set_m0(32'hFFFF_FFF8, 3);
    expect_txn(1'b0, 32'hFFFF_FFF8, 3, 1'b0, '0, '0, 1'b1);
    next_cycle();

    // Reset during beat 2 of a latency-3 burst
    lat = 3;
    txn_id++;
    set_m0(32'h100, 3);
    repeat (3) @(posedge clk);
    #2;
    check("pre_abort_ram_req", ram_req, 1);
    check("pre_abort_ram_addr", ram_addr, 32'h108);
    rst = 1'b1;
    #1;
    check("abort_ram_req", ram_req, 0);
    check("abort_ram_addr", ram_addr, 0);
    check("abort_m0_done", m0_done, 0);
    m0_req = 1'b0;
    @(negedge clk);
    rst      = 1'b0;
    ref_last = 1'b1;
    next_cycle();
    check("late_ret_m0_rvalid", m0_rvalid, 0);
    check("late_ret_m1_rvalid", m1_rvalid, 0);
    check("late_ret_ram_req", ram_req, 0);
    check("late_ret_m0_done", m0_done, 0);
    next_cycle();
    lat = 1;
    set_m1(1'b0, 32'h40, '0, '0);
    expect_txn(1'b1, 32'h40, 0, 1'b0, '0, '0, 1'b1);
    next_cycle();

    // Randomized mix, including simultaneous requests
    for (int n = 0; n < 24; n++) begin
      kind = int'($urandom_range(0, 3));
      lat  = int'($urandom_range(1, 4));
      a0   = $urandom & 32'hFFFF_FFFC;
      a1   = $urandom & 32'hFFFF_FFFC;
      l    = int'($urandom_range(0, 3));
      w    = 1'($urandom_range(0, 1));
      wd   = $urandom;
      ws   = 4'($urandom_range(1, 15));
      if (!w) begin
        wd = '0;
        ws = '0;
      end
      case (kind)
        0: begin
          set_m0(a0, l);
          expect_txn(1'b0, a0, l, 1'b0, '0, '0, 1'b1);
        end
        1: begin
          set_m1(1'b0, a1, '0, '0);
          expect_txn(1'b1, a1, 0, 1'b0, '0, '0, 1'b1);
        end
        2: begin
          set_m1(1'b1, a1, $urandom, 4'($urandom_range(1, 15)));
          expect_txn(1'b1, a1, 0, 1'b1, m1_wdata, m1_wstrb, 1'b1);
        end
        default: begin
          first = !ref_last;
          set_m0(a0, l);
          set_m1(w, a1, wd, ws);
          if (!first) begin
            expect_txn(1'b0, a0, l, 1'b0, '0, '0, 1'b1);
            next_cycle();
            expect_txn(1'b1, a1, 0, w, wd, ws, 1'b1);
          end else begin
            expect_txn(1'b1, a1, 0, w, wd, ws, 1'b1);
            next_cycle();
            expect_txn(1'b0, a0, l, 1'b0, '0, '0, 1'b1);
          end
        end
      endcase
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the SoC's single-port data RAM between two masters: M0 (ICache line refill, read bursts) and M1 (LSU data port, single-beat reads/writes).
- Sits between rvcore and ram. It does round-robin arbitration, sequences burst addresses and routes read responses back to the owning master.
- Ownership is held until the whole transaction completes, including all outstanding read returns.

Parameters:
- AW, 32, address width (byte address).
- DW, 32, data width; beat stride is DW/8 bytes.
- LW, 2, burst-length field width; max beats = 2^LW.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  M0 transaction request; held stable until m0_done.
- m0_addr  in  AW  M0 base address, aligned to DW/8.
- m0_len  in  LW  M0 beats minus 1.
- m0_done  out  1  pulse: M0 transaction complete.
- m0_rvalid  out  1  M0 read beat valid.
- m0_rdata  out  DW  M0 read data.
- m1_req  in  1  M1 request; held stable until m1_done.
- m1_we  in  1  M1 write enable.
- m1_addr  in  AW  M1 address.
- m1_wdata  in  DW  M1 write data.
- m1_wstrb  in  DW/8  M1 byte strobes.
- m1_done  out  1  pulse: M1 transaction complete.
- m1_rvalid  out  1  M1 read beat valid.
- m1_rdata  out  DW  M1 read data.
- ram_req  out  1  RAM access strobe, one beat per cycle.
- ram_we  out  1  RAM write.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_wstrb  out  DW/8  RAM byte strobes.
- ram_rvalid  in  1  RAM read data valid (any fixed latency ≥1).
- ram_rdata  in  DW  RAM read data.

Behaviour:
- Reset (async, rst=1):
  - State=IDLE; owner=0; last_owner=1, so M0 wins the first tie.
  - Beat counters=0.
  - All outputs 0: ram_*, m*_done, m*_rvalid; m*_rdata=0.
- States: IDLE, ISSUE, WAIT.
- IDLE arbitration:
  - Only one requester active: grant it.
  - Both active: grant the one that is not last_owner.
  - On grant, register owner, base address, len and we, then go to ISSUE on the next edge. Latency is 1 cycle from req to the first ram_req.
  - M1 with we=1 is forced to len=0. M1 len is always 0.
- ISSUE:
  - ram_req=1 every cycle; ram_addr = base + beat*(DW/8).
  - Beat counter increments; the address wraps modulo 2^AW (no line wrap).
  - ram_we, ram_wdata and ram_wstrb come from M1 only when owner=1 and we=1; otherwise ram_we=0 and ram_wstrb=0.
  - Write completion: the single write beat asserts done of the owner combinationally in the same cycle, then the block returns to IDLE.
  - Read completion: after beat==len has issued, go to WAIT. If the final response also arrives that cycle, go straight to IDLE.
- Read returns:
  - ram_rvalid routes to the owner's m*_rvalid/m*_rdata combinationally; the other master's rvalid stays 0.
  - The response counter increments per ram_rvalid. Responses arriving during ISSUE are counted too.
  - done pulses with the rvalid whose count == len. The block then goes to IDLE, last_owner=owner.
- ram_rvalid in IDLE is ignored, not routed. Ownership is never switched mid-transaction.
- A requester must drop req the cycle after done. A req still high in IDLE is treated as a new request.
- Reset mid-transaction:
  - Aborts immediately and drops ram_req the same cycle.
  - Counters clear; late RAM returns after reset are ignored.
- Back-to-back: IDLE always lasts exactly 1 cycle between transactions. Maximum throughput is one transaction per (len+1+RAM latency+1) cycles.
- Block-level assertions:
  - ram_req is never high in IDLE or WAIT.
  - m0_rvalid and m1_rvalid are never both high.

Test Plan:
- M0 only, addr=0x100, len=3, RAM latency 1:
  - ram_addr 0x100, 0x104, 0x108, 0x10C on 4 consecutive cycles starting 1 cycle after req.
  - 4 m0_rvalid beats; m0_done with the 4th; m1_rvalid stays 0.
- M1 write, addr=0x20, wdata=0xDEADBEEF, wstrb=0xF:
  - A single ram_req with ram_we=1 and matching data, 1 cycle after req.
  - m1_done in the same cycle; IDLE next.
- Both req in the same cycle after reset:
  - M0 granted first (len=1).
  - M1 read at 0x40 granted in the IDLE cycle after m0_done; m1_rdata equals RAM word at 0x40.
- Both req held through 3 transactions: owners alternate M0, M1, M0.
- RAM latency 3, M0 len=3:
  - State enters WAIT after the 4th issue.
  - m0_done coincides with the 4th ram_rvalid; no ram_req during WAIT.
- Reset asserted during ISSUE beat 2 of an M0 len=3 burst:
  - ram_req=0 immediately; no done.
  - After release, an M1 request is served normally and late returns are not routed.
